// File: rtl/fc_layer_pkg.sv
// Shared definitions for the CNN datapath stages: FSM state encoding,
// default fixed-point widths and a width helper.
package fc_layer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    STORE = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_W_FRAC = 6;
  localparam int DEF_ACC_W  = 32;

  // Ceiling log2, never below 1 so that counters and addresses keep a real bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fc_layer_sat_shift.sv
// Rescale an accumulator by an arithmetic right shift (floor) and clamp it
// into the signed output range.
module fc_layer_sat_shift #(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 16,
  parameter int SHIFT  = 6
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [DATA_W-1:0] result
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;

  assign shifted = $signed(acc) >>> SHIFT;

  always_comb begin
    if (shifted > MAX_V)
      result = MAX_V[DATA_W-1:0];
    else if (shifted < MIN_V)
      result = MIN_V[DATA_W-1:0];
    else
      result = shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/fc_layer.sv
// Sequential dense layer: one MAC per clock over a captured feature vector,
// bias add, rescale/saturate, and a one-cycle valid pulse per result vector.
module fc_layer
  import fc_layer_pkg::*;
#(
  parameter int IN_LEN   = 8,
  parameter int OUT_LEN  = 4,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = 8,
  parameter int W_FRAC   = DEF_W_FRAC,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [IN_LEN*DATA_W-1:0]               data_in,
  input  logic                                   data_valid,
  output logic                                   in_ready,
  input  logic                                   w_wr_en,
  input  logic [clog2(IN_LEN*OUT_LEN)-1:0]       w_addr,
  input  logic [WEIGHT_W-1:0]                    w_data,
  input  logic                                   b_wr_en,
  input  logic [clog2(OUT_LEN)-1:0]              b_addr,
  input  logic [DATA_W-1:0]                      b_data,
  output logic [OUT_LEN*DATA_W-1:0]              data_out,
  output logic                                   data_out_valid
);

  localparam int NW = IN_LEN * OUT_LEN;
  localparam int AW = clog2(NW);
  localparam int IW = clog2(IN_LEN);
  localparam int OW = clog2(OUT_LEN);
  localparam int PW = DATA_W + WEIGHT_W;

  state_t state_reg, state_next;

  logic [IW-1:0]              i_reg;
  logic [OW-1:0]              o_reg;
  logic signed [ACC_W-1:0]    acc_reg;
  logic                       dout_valid_reg;
  logic signed [DATA_W-1:0]   x_in     [IN_LEN];
  logic signed [DATA_W-1:0]   x_reg    [IN_LEN];
  logic signed [DATA_W-1:0]   dout_reg [OUT_LEN];
  logic signed [WEIGHT_W-1:0] w_mem    [NW];
  logic signed [DATA_W-1:0]   b_mem    [OUT_LEN];

  logic                       last_i, last_o;
  logic                       w_addr_ok, b_addr_ok;
  logic [AW-1:0]              w_idx;
  logic signed [PW-1:0]       prod;
  logic signed [DATA_W-1:0]   b_sel;
  logic signed [ACC_W-1:0]    bias_acc;
  logic [DATA_W-1:0]          sat_out;

  for (genvar gi = 0; gi < IN_LEN; gi++) begin : g_unpack
    assign x_in[gi] = data_in[gi*DATA_W +: DATA_W];
  end

  for (genvar gi = 0; gi < OUT_LEN; gi++) begin : g_pack
    assign data_out[gi*DATA_W +: DATA_W] = dout_reg[gi];
  end

  // Address range checks collapse to constants when the depth fills the address space.
  if (NW == (1 << AW)) begin : g_w_full
    assign w_addr_ok = 1'b1;
  end else begin : g_w_part
    assign w_addr_ok = {1'b0, w_addr} < (AW+1)'(NW);
  end

  if (OUT_LEN == (1 << OW)) begin : g_b_full
    assign b_addr_ok = 1'b1;
  end else begin : g_b_part
    assign b_addr_ok = {1'b0, b_addr} < (OW+1)'(OUT_LEN);
  end

  assign last_i   = (i_reg == IW'(IN_LEN - 1));
  assign last_o   = (o_reg == OW'(OUT_LEN - 1));
  assign w_idx    = AW'(o_reg) * AW'(IN_LEN) + AW'(i_reg);
  assign prod     = PW'(x_reg[i_reg]) * PW'(w_mem[w_idx]);
  assign b_sel    = (state_reg == IDLE) ? b_mem[0] : b_mem[o_reg + OW'(1)];
  assign bias_acc = ACC_W'(b_sel) <<< W_FRAC;

  fc_layer_sat_shift #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .SHIFT (W_FRAC)
  ) u_sat (
    .acc   (acc_reg),
    .result(sat_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (data_valid) state_next = MAC;
      MAC:     if (last_i) state_next = STORE;
      STORE:   state_next = last_o ? IDLE : MAC;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready       = (state_reg == IDLE);
    data_out_valid = dout_valid_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_reg          <= '0;
      o_reg          <= '0;
      acc_reg        <= '0;
      dout_valid_reg <= 1'b0;
      for (int k = 0; k < IN_LEN; k++)  x_reg[k]    <= '0;
      for (int k = 0; k < OUT_LEN; k++) dout_reg[k] <= '0;
    end else begin
      dout_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (data_valid) begin
            x_reg   <= x_in;
            acc_reg <= bias_acc;
            i_reg   <= '0;
            o_reg   <= '0;
          end
        end
        MAC: begin
          acc_reg <= acc_reg + ACC_W'(prod);
          i_reg   <= last_i ? '0 : i_reg + IW'(1);
        end
        STORE: begin
          dout_reg[o_reg] <= sat_out;
          if (!last_o) begin
            o_reg   <= o_reg + OW'(1);
            i_reg   <= '0;
            acc_reg <= bias_acc;
          end else begin
            dout_valid_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Coefficients only change between vectors so a run always sees one consistent set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NW; k++)      w_mem[k] <= '0;
      for (int k = 0; k < OUT_LEN; k++) b_mem[k] <= '0;
    end else if (state_reg == IDLE) begin
      if (w_wr_en && w_addr_ok) w_mem[w_addr] <= w_data;
      if (b_wr_en && b_addr_ok) b_mem[b_addr] <= b_data;
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Randomized self-checking bench for fc_layer: a transaction-level model
// predicts readiness, the valid pulse and the result vector every cycle.
module tb_fc_layer;

  localparam int IN_LEN   = 8;
  localparam int OUT_LEN  = 4;
  localparam int DATA_W   = 16;
  localparam int WEIGHT_W = 8;
  localparam int W_FRAC   = 6;
  localparam int ACC_W    = 32;
  localparam int NW       = IN_LEN * OUT_LEN;
  localparam int LAT      = OUT_LEN * (IN_LEN + 1);

  logic                       clk = 1'b0;
  logic                       rst;
  logic [IN_LEN*DATA_W-1:0]   data_in;
  logic                       data_valid;
  logic                       in_ready;
  logic                       w_wr_en;
  logic [4:0]                 w_addr;
  logic [WEIGHT_W-1:0]        w_data;
  logic                       b_wr_en;
  logic [1:0]                 b_addr;
  logic [DATA_W-1:0]          b_data;
  logic [OUT_LEN*DATA_W-1:0]  data_out;
  logic                       data_out_valid;

  always #5 clk = ~clk;

  fc_layer #(
    .IN_LEN  (IN_LEN),
    .OUT_LEN (OUT_LEN),
    .DATA_W  (DATA_W),
    .WEIGHT_W(WEIGHT_W),
    .W_FRAC  (W_FRAC),
    .ACC_W   (ACC_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .in_ready      (in_ready),
    .w_wr_en       (w_wr_en),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .b_wr_en       (b_wr_en),
    .b_addr        (b_addr),
    .b_data        (b_data),
    .data_out      (data_out),
    .data_out_valid(data_out_valid)
  );

  int errors = 0;
  int checks = 0;
  int vec_no = 0;
  bit started = 1'b0;

  // Model state: coefficients, the in-flight result and the last delivered one.
  int w_m[NW];
  int b_m[OUT_LEN];
  int pend[OUT_LEN];
  int last_out[OUT_LEN];
  bit m_idle = 1'b1;
  bit valid_exp = 1'b0;
  int countdown = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int slot(input int o);
    return int'($signed(data_out[o*DATA_W +: DATA_W]));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle    = 1'b1;
      valid_exp = 1'b0;
      countdown = 0;
      for (int k = 0; k < NW; k++) w_m[k] = 0;
      for (int k = 0; k < OUT_LEN; k++) begin
        b_m[k] = 0;
        last_out[k] = 0;
      end
    end else begin
      valid_exp = 1'b0;
      if (m_idle) begin
        if (data_valid) begin
          for (int o = 0; o < OUT_LEN; o++) begin
            longint acc;
            longint r;
            acc = longint'(b_m[o]) * 64;
            for (int i = 0; i < IN_LEN; i++)
              acc += longint'($signed(data_in[i*DATA_W +: DATA_W])) * longint'(w_m[o*IN_LEN+i]);
            r = acc >>> W_FRAC;
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            pend[o] = int'(r);
          end
          m_idle    = 1'b0;
          countdown = LAT;
        end
        if (w_wr_en) w_m[w_addr] = int'($signed(w_data));
        if (b_wr_en) b_m[b_addr] = int'($signed(b_data));
      end else begin
        countdown--;
        if (countdown == 0) begin
          m_idle    = 1'b1;
          valid_exp = 1'b1;
          for (int o = 0; o < OUT_LEN; o++) last_out[o] = pend[o];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", int'(in_ready), int'(m_idle));
      chk("data_out_valid", int'(data_out_valid), int'(valid_exp));
      if (m_idle)
        for (int o = 0; o < OUT_LEN; o++) chk("data_out", slot(o), last_out[o]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int a, input int v);
    w_wr_en = 1'b1;
    w_addr  = 5'(a);
    w_data  = 8'(v);
    tick();
    w_wr_en = 1'b0;
  endtask

  task automatic wr_b(input int a, input int v);
    b_wr_en = 1'b1;
    b_addr  = 2'(a);
    b_data  = 16'(v);
    tick();
    b_wr_en = 1'b0;
  endtask

  task automatic set_x_all(input int v);
    for (int i = 0; i < IN_LEN; i++) data_in[i*DATA_W +: DATA_W] = 16'(v);
  endtask

  task automatic set_x_rand();
    for (int i = 0; i < IN_LEN; i++) data_in[i*DATA_W +: DATA_W] = 16'($urandom);
  endtask

  task automatic load_rand_coeffs();
    for (int a = 0; a < NW; a++) wr_w(a, int'($urandom_range(0, 255)) - 128);
    for (int a = 0; a < OUT_LEN; a++) wr_b(a, int'($urandom_range(0, 65535)) - 32768);
  endtask

  // Present one vector, wait for its result pulse, optionally poke the block while busy.
  task automatic run_vec(input bit disturb);
    int n;
    n = 0;
    while (!m_idle && n < 200) begin
      tick();
      n++;
    end
    if (!m_idle) chk("idle_timeout", 0, 1);
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    n = 0;
    while (!data_out_valid && n < 100) begin
      tick();
      n++;
      if (disturb) begin
        if (n == 5) begin
          data_valid = 1'b1;
          set_x_rand();
        end
        if (n == 6) data_valid = 1'b0;
        if (n == 12) begin
          w_wr_en = 1'b1;
          w_addr  = 5'($urandom);
          w_data  = 8'($urandom);
          b_wr_en = 1'b1;
          b_addr  = 2'($urandom);
          b_data  = 16'($urandom);
        end
        if (n == 13) begin
          w_wr_en = 1'b0;
          b_wr_en = 1'b0;
        end
      end
    end
    chk("latency", n, LAT);
    vec_no++;
    $display("vec %0d: latency=%0d out=%0d,%0d,%0d,%0d", vec_no, n, slot(0), slot(1), slot(2), slot(3));
  endtask

  task automatic lit4(input string name, input int e0, input int e1, input int e2, input int e3);
    chk(name, slot(0), e0);
    chk(name, slot(1), e1);
    chk(name, slot(2), e2);
    chk(name, slot(3), e3);
  endtask

  initial begin
    rst = 1'b1;
    data_in = '0;
    data_valid = 1'b0;
    w_wr_en = 1'b0;
    w_addr = '0;
    w_data = '0;
    b_wr_en = 1'b0;
    b_addr = '0;
    b_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    started = 1'b1;
    tick();
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_valid", int'(data_out_valid), 0);

    // Cleared coefficients give an all-zero result for any input.
    set_x_rand();
    run_vec(1'b0);
    lit4("reset_coeffs", 0, 0, 0, 0);

    for (int a = 0; a < NW; a++) wr_w(a, ((a / IN_LEN) == (a % IN_LEN)) ? 64 : 0);
    for (int i = 0; i < IN_LEN; i++) data_in[i*DATA_W +: DATA_W] = 16'(256 * (i + 1));
    run_vec(1'b0);
    lit4("identity", 256, 512, 768, 1024);

    for (int a = 0; a < NW; a++) wr_w(a, -64);
    for (int a = 0; a < OUT_LEN; a++) wr_b(a, 100);
    set_x_all(256);
    run_vec(1'b0);
    lit4("bias_neg", -1948, -1948, -1948, -1948);

    for (int a = 0; a < NW; a++) wr_w(a, 127);
    set_x_all(32767);
    run_vec(1'b0);
    lit4("sat_pos", 32767, 32767, 32767, 32767);

    for (int a = 0; a < NW; a++) wr_w(a, -128);
    run_vec(1'b0);
    lit4("sat_neg", -32768, -32768, -32768, -32768);

    load_rand_coeffs();
    for (int k = 0; k < 4; k++) begin
      set_x_rand();
      run_vec(1'b1);
    end

    // Back-to-back: each new vector lands in the previous valid cycle.
    for (int k = 0; k < 3; k++) begin
      set_x_rand();
      run_vec(1'b0);
    end

    set_x_rand();
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #2;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_valid", int'(data_out_valid), 0);
    chk("midrst_dout", slot(0), 0);
    tick();
    rst = 1'b0;
    repeat (LAT + 5) tick();

    load_rand_coeffs();
    for (int k = 0; k < 3; k++) begin
      set_x_rand();
      run_vec(1'b1);
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fc_layer.md
Name: fc_layer

Overview:
- Sequential fully-connected (dense) layer that sits directly downstream of the max-pooling stage in the keyword-spotting CNN.
- Captures one flattened pooled feature vector and computes OUT_LEN signed dot products against a locally stored weight matrix, using one multiply-accumulate per clock.
- Adds a bias to each dot product, rescales and saturates it, and emits the whole result vector to the classifier/argmax stage with a one-cycle valid pulse.

Parameters:
- IN_LEN, 8, number of input features per vector.
- OUT_LEN, 4, number of output neurons.
- DATA_W, 16, signed input/output/bias width (fixed-point, same format in and out).
- WEIGHT_W, 8, signed weight width.
- W_FRAC, 6, fractional bits of the weights.
- ACC_W, 32, signed accumulator width; must be at least DATA_W+WEIGHT_W+clog2(IN_LEN)+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  IN_LEN*DATA_W  flattened input vector; feature i occupies [i*DATA_W +: DATA_W], signed.
- data_valid  in  1  input vector present; accepted only when in_ready=1.
- in_ready  out  1  high when in the IDLE state.
- w_wr_en  in  1  weight write strobe.
- w_addr  in  clog2(IN_LEN*OUT_LEN)  weight index = o*IN_LEN+i.
- w_data  in  WEIGHT_W  signed weight.
- b_wr_en  in  1  bias write strobe.
- b_addr  in  clog2(OUT_LEN)  bias index.
- b_data  in  DATA_W  signed bias, same format as the data.
- data_out  out  OUT_LEN*DATA_W  result vector; neuron o occupies [o*DATA_W +: DATA_W].
- data_out_valid  out  1  one-cycle pulse when data_out is complete.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - state = IDLE, so in_ready = 1.
  - data_out = 0, data_out_valid = 0.
  - i and o counters = 0, accumulator = 0.
  - Weight and bias arrays = 0.
- States: IDLE, MAC, STORE.
- IDLE:
  - If data_valid=1, register data_in into an internal vector x.
  - Load acc = sign-extended bias[0] <<< W_FRAC, set i=0, o=0, go to MAC.
  - data_out_valid is forced to 0 on every IDLE cycle in which it is not being set.
- MAC:
  - Each cycle, acc += x[i] * w[o*IN_LEN+i], computed as a full-width signed product.
  - Increment i; when i == IN_LEN-1, go to STORE.
- STORE:
  - Compute r = acc >>> W_FRAC (arithmetic shift, floor).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and write it to data_out slot o.
  - If o < OUT_LEN-1: increment o, set i=0, load acc = bias[o+1] <<< W_FRAC, go to MAC.
  - Else: set data_out_valid=1 and go to IDLE.
- Latency:
  - data_out_valid rises exactly OUT_LEN*(IN_LEN+1) cycles after the acceptance edge (36 cycles at default parameters).
  - data_out_valid is high for exactly one cycle.
- data_out holding rules:
  - data_out holds its value until overwritten slot by slot by the next vector.
  - Slots are updated progressively; data_out is valid only when qualified by data_out_valid.
- Back-to-back: data_valid in the cycle data_out_valid is high is accepted, because the block is already in IDLE.
- data_valid while not in IDLE is ignored; the upstream stage must hold data_valid until it sees in_ready.
- Weight and bias writes:
  - Writes are applied only in IDLE; strobes in MAC or STORE are silently dropped, so the coefficients never change mid-vector.
  - Out-of-range addresses are ignored.
  - A weight write and a bias write in the same cycle both take effect.
- Reset mid-operation: the block returns to IDLE immediately, data_out and data_out_valid clear to 0, and weights and biases clear.

Decomposition:
- Shared include (nn_defs) holds:
  - state encodings IDLE=0, MAC=1, STORE=2;
  - a clog2 function;
  - default widths DATA_W, W_FRAC, ACC_W, shared with the conv and maxpool stages.
- One sub-module, sat_shift:
  - Parameters ACC_W, DATA_W, SHIFT.
  - Purely combinational: arithmetic right shift then signed saturation.
  - Reused by the conv stage.

Test Plan:
- Reset: assert rst mid-idle -> in_ready=1, data_out=0, data_out_valid=0, and all weight reads give 0.
- Identity: w[o][o]=64 (1.0), all other weights 0, biases 0, x=[256,512,...,2048] -> data_out=[256,512,768,1024], with the valid pulse exactly 36 cycles after acceptance.
- Bias and negative values: all weights -64, biases 100, all x=256 -> every output = -1948.
- Saturation: all weights 127, all x=32767 -> outputs 32767; all weights -128 -> outputs -32768.
- Busy rules:
  - data_valid pulsed at cycle 5 of a run -> ignored.
  - A w_wr_en during MAC -> dropped, and the result is unchanged versus the golden model.
  - A new vector presented in the data_out_valid cycle -> accepted, and a second valid pulse follows 36 cycles later.
- Reset mid-operation: assert rst 10 cycles into a run -> IDLE, data_out=0, no valid pulse; a rerun after reloading coefficients matches the golden model.
